// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
// Saturation bounds are generated at a fixed maximum width and sliced by the user.
package adder_pkg;

    localparam int unsigned OP_SUB   = 0;
    localparam int unsigned OP_SAT   = 1;
    localparam int unsigned OpW      = 2;
    localparam int unsigned MaxWidth = 64;

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

    // Largest positive signed value of the given width, zero-extended to MaxWidth.
    function automatic logic [MaxWidth-1:0] sat_max(input int unsigned width);
        return {MaxWidth{1'b1}} >> (MaxWidth - width + 1);
    endfunction

    function automatic logic [MaxWidth-1:0] sat_min(input int unsigned width);
        return MaxWidth'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered carry slice: adds bits [Idx*SliceW +: SliceW] and forwards the
// operands, the partially built sum and the op flags to the next slice.
module adder_slice
    import adder_pkg::*;
#(
    parameter int unsigned Width  = 32,
    parameter int unsigned SliceW = 16,
    parameter int unsigned Idx    = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [Width-1:0] sum_i,
    input  logic             carry_i,
    input  logic [OpW-1:0]   op_i,
    output logic             valid_o,
    output logic [Width-1:0] a_o,
    output logic [Width-1:0] b_o,
    output logic [Width-1:0] sum_o,
    output logic             carry_o,
    output logic [OpW-1:0]   op_o
);

    logic             valid_d, valid_q;
    logic [Width-1:0] a_d, a_q;
    logic [Width-1:0] b_d, b_q;
    logic [Width-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;
    logic [OpW-1:0]   op_d, op_q;
    logic [SliceW:0]  part;

    always_comb begin
        part = {1'b0, a_i[Idx*SliceW +: SliceW]}
             + {1'b0, b_i[Idx*SliceW +: SliceW]}
             + {{SliceW{1'b0}}, carry_i};

        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        op_d    = op_q;

        // Bubbles load like data; only the valid bit distinguishes them.
        if (adv_i) begin
            valid_d = valid_i;
            a_d     = a_i;
            b_d     = b_i;
            sum_d   = sum_i;
            sum_d[Idx*SliceW +: SliceW] = part[SliceW-1:0];
            carry_d = part[SliceW];
            op_d    = op_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        valid_o = valid_q;
        a_o     = a_q;
        b_o     = b_q;
        sum_o   = sum_q;
        carry_o = carry_q;
        op_o    = op_q;
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract with optional signed saturation: STAGES carry slices in a
// lock-step pipeline behind a valid/ready handshake.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int unsigned S = slice_width(WIDTH, STAGES);
    localparam logic [MaxWidth-1:0] SatMaxFull = sat_max(WIDTH);
    localparam logic [MaxWidth-1:0] SatMinFull = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SatMax = SatMaxFull[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SatMin = SatMinFull[WIDTH-1:0];

    logic             adv;
    logic [WIDTH-1:0] b_mod;
    logic [OpW-1:0]   op_in;

    logic             valid_s [STAGES];
    logic [WIDTH-1:0] a_s     [STAGES];
    logic [WIDTH-1:0] b_s     [STAGES];
    logic [WIDTH-1:0] sum_s   [STAGES];
    logic             carry_s [STAGES];
    logic [OpW-1:0]   op_s    [STAGES];

    logic [WIDTH-1:0] raw;
    logic             a_msb, b_msb, ovf;
    logic             unused_last;

    always_comb begin
        b_mod = in_sub ? ~in_b : in_b;
        op_in = '0;
        op_in[OP_SUB] = in_sub;
        op_in[OP_SAT] = in_sat;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] a_in, b_in, sum_in;
        logic             c_in;
        logic [OpW-1:0]   o_in;

        if (k == 0) begin : g_src
            // Subtraction is A + ~B + 1: the +1 enters as carry-in of slice 0.
            always_comb begin
                v_in   = in_valid;
                a_in   = in_a;
                b_in   = b_mod;
                sum_in = '0;
                c_in   = in_sub;
                o_in   = op_in;
            end
        end else begin : g_src
            always_comb begin
                v_in   = valid_s[k-1];
                a_in   = a_s[k-1];
                b_in   = b_s[k-1];
                sum_in = sum_s[k-1];
                c_in   = carry_s[k-1];
                o_in   = op_s[k-1];
            end
        end

        adder_slice #(
            .Width (WIDTH),
            .SliceW(S),
            .Idx   (k)
        ) u_slice (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .adv_i  (adv),
            .valid_i(v_in),
            .a_i    (a_in),
            .b_i    (b_in),
            .sum_i  (sum_in),
            .carry_i(c_in),
            .op_i   (o_in),
            .valid_o(valid_s[k]),
            .a_o    (a_s[k]),
            .b_o    (b_s[k]),
            .sum_o  (sum_s[k]),
            .carry_o(carry_s[k]),
            .op_o   (op_s[k])
        );
    end

    // Saturation is a pure function of the last stage's registers, so it stays
    // stable while stalled and reads as zero straight after reset.
    always_comb begin
        raw   = sum_s[STAGES-1];
        a_msb = a_s[STAGES-1][WIDTH-1];
        b_msb = b_s[STAGES-1][WIDTH-1];
        ovf   = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);

        out_sum = raw;
        if (op_s[STAGES-1][OP_SAT] && ovf) begin
            out_sum = a_msb ? SatMin : SatMax;
        end

        out_valid = valid_s[STAGES-1];
        out_carry = carry_s[STAGES-1];
        out_ovf   = ovf;
        adv       = !valid_s[STAGES-1] || out_ready;
        in_ready  = adv;
    end

    assign unused_last = ^{a_s[STAGES-1][WIDTH-2:0], b_s[STAGES-1][WIDTH-2:0],
                           op_s[STAGES-1][OP_SUB]};

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: directed vectors on a 32/2 instance plus
// random traffic with backpressure on 16/4 and 8/1 instances.
module tb_adder_pipe;

    typedef logic [33:0] exp_t;  // {ovf, carry, sum}

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        sat;
        exp_t        exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_seen = 0;
    logic [1:0] rand_done = 2'b00;

    logic        rst_n, in_valid, in_ready, in_sub, in_sat;
    logic        out_valid, out_ready, out_carry, out_ovf;
    logic [31:0] in_a, in_b, out_sum;
    logic        rst_n_r;

    exp_t sb_q[$];

    adder_pipe #(
        .WIDTH (32),
        .STAGES(2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .in_sat   (in_sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry),
        .out_ovf  (out_ovf)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic ovf, input logic c, input logic [31:0] s);
        return {ovf, c, s};
    endfunction

    // Behavioural reference for the random runs, width w <= 32.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic sat, input int w);
        logic [31:0] mask, am, bp, r;
        logic [32:0] full;
        logic        c, ovf;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am   = a & mask;
        bp   = (sub ? ~b : b) & mask;
        full = {1'b0, am} + {1'b0, bp} + {32'b0, sub};
        c    = full[w];
        r    = full[31:0] & mask;
        ovf  = (am[w-1] == bp[w-1]) && (r[w-1] != am[w-1]);
        if (sat && ovf) r = am[w-1] ? (32'h1 << (w - 1)) : ((32'h1 << (w - 1)) - 32'h1);
        return {ovf, c, r};
    endfunction

    // Main monitor: scoreboard pop on transfer, plus stall stability.
    logic prev_stall = 1'b0;
    exp_t held;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && out_valid) check("stall_hold", {out_ovf, out_carry, out_sum}, held);
            if (out_valid && !out_ready) begin
                stall_seen++;
                check("stall_in_ready", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got sum 0x%0h, expected no output", out_sum);
                end else begin
                    check("result", {out_ovf, out_carry, out_sum}, sb_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            held = {out_ovf, out_carry, out_sum};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic sat, input exp_t exp, input bit track);
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_sat = sat;
        in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t == 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL issue_timeout: got in_ready 0 for 100 cycles, expected 1");
                break;
            end
        end
        if (track) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(posedge clk);
        #1;
        check(name, sb_q.size(), 0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_FFFF, 32'h1, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h0001_0000)};
        vecs[1] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(1'b0, 1'b1, 32'h0000_0000)};
        vecs[2] = '{32'h8000_0000, 32'h1, 1'b1, 1'b1, mk(1'b1, 1'b1, 32'h8000_0000)};
        vecs[3] = '{32'h8000_0000, 32'h1, 1'b1, 1'b0, mk(1'b1, 1'b1, 32'h7FFF_FFFF)};
        vecs[4] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, mk(1'b1, 1'b0, 32'h7FFF_FFFF)};
        vecs[5] = '{32'd10, 32'd3, 1'b1, 1'b0, mk(1'b0, 1'b1, 32'd7)};
        vecs[6] = '{32'd3, 32'd10, 1'b1, 1'b0, mk(1'b0, 1'b0, 32'hFFFF_FFF9)};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, mk(1'b1, 1'b1, 32'h8000_0000)};

        rst_n = 1'b0;
        in_valid = 1'b1;
        in_a = 32'hDEAD_BEEF;
        in_b = 32'h1;
        in_sub = 1'b0;
        in_sat = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_out_valid", out_valid, 0);
            check("reset_out_sum", out_sum, 0);
            check("reset_in_ready", in_ready, 1);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // Latency: accept edge closes cycle 0, result visible in cycle 2.
        issue(32'd5, 32'd7, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'd12), 1'b1);
        @(negedge clk);
        check("latency_early", out_valid, 0);
        @(negedge clk);
        check("latency_on_time", out_valid, 1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat, vecs[i].exp, 1'b1);
        drain("directed_drain");

        // Backpressure mid-stream.
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    issue(32'(i * 100), 32'(i * 7), 1'b0, 1'b0,
                          mk(1'b0, 1'b0, 32'(i * 107)), 1'b1);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("backpressure_drain");
        check("stall_observed", stall_seen > 0, 1);

        // Two ops held in flight by backpressure, then reset: neither may appear.
        out_ready = 1'b0;
        issue(32'd1, 32'd2, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'd3), 1'b0);
        issue(32'd3, 32'd4, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'd7), 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("midreset_out_valid", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midreset_quiet", out_valid, 0);
        end
        @(posedge clk);
        #1;
        issue(32'h10, 32'h20, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h30), 1'b1);
        drain("post_reset_drain");

        for (int t = 0; t < 20000 && rand_done != 2'b11; t++) @(posedge clk);
        if (rand_done != 2'b11) begin
            n_checks++;
            n_fail++;
            $display("FAIL random_timeout: got done 0b%b, expected 0b11", rand_done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst_n_r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n_r = 1'b1;
    end

    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int W  = (g == 0) ? 16 : 8;
        localparam int ST = (g == 0) ? 4 : 1;

        logic         iv, ir, isub, isat, ov, ordy, oc, oo;
        logic [W-1:0] ia, ib, os;
        exp_t         q[$];

        adder_pipe #(
            .WIDTH (W),
            .STAGES(ST)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n_r),
            .in_valid (iv),
            .in_ready (ir),
            .in_a     (ia),
            .in_b     (ib),
            .in_sub   (isub),
            .in_sat   (isat),
            .out_valid(ov),
            .out_ready(ordy),
            .out_sum  (os),
            .out_carry(oc),
            .out_ovf  (oo)
        );

        initial begin : drive
            logic [31:0] ra, rb;
            int acc;
            acc = 0;
            iv = 1'b0;
            ia = '0;
            ib = '0;
            isub = 1'b0;
            isat = 1'b0;
            @(posedge rst_n_r);
            @(posedge clk);
            #1;
            while (acc < 1000) begin
                ra = $urandom;
                rb = $urandom;
                ia = ra[W-1:0];
                ib = rb[W-1:0];
                isub = 1'($urandom_range(0, 1));
                isat = 1'($urandom_range(0, 1));
                iv = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (iv && ir) begin
                    q.push_back(model(ra, rb, isub, isat, W));
                    acc++;
                end
                @(posedge clk);
                #1;
            end
            iv = 1'b0;
            for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
            #1;
            check($sformatf("rand_w%0d_drain", W), q.size(), 0);
            rand_done[g] = 1'b1;
        end

        initial begin : ready_gen
            ordy = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                ordy = ($urandom_range(0, 3) != 0);
            end
        end

        always @(negedge clk) begin
            if (rst_n_r && ov && ordy) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rand_w%0d_unexpected: got sum 0x%0h, expected no output",
                             W, os);
                end else begin
                    check($sformatf("rand_w%0d_result", W),
                          {oo, oc, {(32 - W){1'b0}}, os}, q.pop_front());
                end
            end
        end
    end

endmodule
